interp_ram_arbiter: RTL and testbench
=====================================

Name: interp_ram_arbiter

Overview:
Parametrised N-channel arbiter that lets NUM_CH interpolation engines share one single-port RAM. It replaces the tri-stated shared data bus of the single-engine integration top with per-channel request/grant/read-valid handshakes. Round-robin or fixed-priority arbitration is selectable, with optional burst lock and a sticky starvation flag. It sits between the interpolation modules and the RAM instance in the multi-engine accelerator top.

Parameters:
WORD_SIZE, 16, data width
ADDRESS_WIDTH, 16, RAM address width
NUM_CH, 4, requester count (1..16)
RD_LATENCY, 1, RAM read latency in cycles (1..4)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
MAX_WAIT, 64, cycles a request may wait ungranted before starve_err sets

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel access request
ch_we  in  NUM_CH  1 = write, 0 = read
ch_lock  in  NUM_CH  keep priority after this grant (burst)
ch_addr  in  NUM_CH*ADDRESS_WIDTH  packed addresses, channel i at [i*AW +: AW]
ch_wdata  in  NUM_CH*WORD_SIZE  packed write data
ch_gnt  out  NUM_CH  one-hot grant, this cycle
ch_rvalid  out  NUM_CH  one-hot read-data valid
ch_rdata  out  WORD_SIZE  broadcast read data, qualified by ch_rvalid
ram_we  out  1  RAM write enable
ram_addr  out  ADDRESS_WIDTH  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_rdata  in  WORD_SIZE  RAM read data
starve_err  out  1  sticky starvation flag
starve_ch  out  clog2(NUM_CH)  first starved channel

Behaviour:
- Reset (rst low, async): ptr=0, read-tag pipeline cleared, wait counters 0, starve_err=0, starve_ch=0. ch_gnt, ch_rvalid, and ram_we are 0 while in reset.
- Grant: combinational from ch_req and registered ptr. Search priority starts at ptr, wrapping modulo NUM_CH. At most one ch_gnt bit is high. ch_gnt=0 when no request is present.
- RAM command: same cycle as grant. ram_addr, ram_wdata, and ram_we are muxed from the granted channel. With no grant: ram_we=0, ram_addr and ram_wdata hold their last value (registered hold, not X).
- Requester rule: hold req, we, addr, and wdata stable until ch_gnt is seen. One access per grant. Keeping req high means the channel competes again next cycle.
- Pointer update, round-robin mode, on a grant to channel i:
  - ptr <= (i+1) mod NUM_CH.
  - If ch_lock[i] is also high, ptr <= i, so a locking channel wins back-to-back.
- Pointer update, fixed-priority mode: ptr is constant 0 and ch_lock is ignored.
- Read return: a granted read pushes {valid, channel id} into a RD_LATENCY-deep shift register. At the tail:
  - ch_rvalid[id]=1 for one cycle.
  - ch_rdata = ram_rdata.
  - Total latency from grant to rvalid is RD_LATENCY cycles. Reads can be issued every cycle (fully pipelined).
- Writes produce no rvalid. A write in cycle N is visible to a read granted in cycle N+1.
- Starvation, per channel:
  - The wait counter increments while req=1 and gnt=0, and clears on grant or when req drops.
  - When a counter reaches MAX_WAIT, starve_err sets and starve_ch captures the lowest such index.
  - starve_err clears only on reset. Counters saturate at MAX_WAIT.
- NUM_CH=1: the grant equals ch_req[0]; ptr stays 0.
- Reset mid-read: in-flight tags are discarded and no rvalid follows reset release.

Decomposition:
- Shared package interp_pkg holds:
  - constants ARB_RR=0 and ARB_FIXED=1;
  - a clog2 function;
  - a localparam rule for id width, max(1, clog2(NUM_CH)).
- One sub-module, rr_priority_picker:
  - inputs: NUM_CH-bit request vector and start pointer;
  - outputs: one-hot grant and the binary index of the granted channel.

Test Plan:
- Reset and idle: rst low for 3 cycles, then all req=0 → ch_gnt=0, ch_rvalid=0, ram_we=0, starve_err=0.
- Write then read: ch1 writes 0xBEEF to address 0x0010, then reads 0x0010 on the next cycle → the read gnt is followed after RD_LATENCY cycles by ch_rvalid=0b0010 and ch_rdata=0xBEEF.
- Round-robin: all 4 channels hold req (reads) for 8 cycles → grant order 0,1,2,3,0,1,2,3; each rvalid id matches its grant delayed by RD_LATENCY.
- Lock burst: ch2 holds req with lock=1 for 3 cycles while ch0 and ch3 request → ch2 granted 3 consecutive cycles; when ch2 drops lock, ch3 is granted next.
- Fixed priority and starvation: ARB_MODE=1, MAX_WAIT=8, ch0 and ch3 requesting continuously → only ch0 is granted; starve_err=1 and starve_ch=3 on the 8th waiting cycle, and starve_err stays high.
- Reset mid-read: issue a read, assert rst the cycle after grant → no ch_rvalid after release and ptr=0 (ch0 granted first).

Source files
------------

// File: rtl/interp_pkg.sv
// Shared constants, types and width helpers for the multi-engine RAM arbiter.
package interp_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Read tags are sized for the largest supported channel count (16).
  localparam int unsigned TAG_IDW = 4;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } rd_tag_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/interp_ram_arbiter_if.sv
// Channel-side handshakes and RAM-side command/data bundle of the arbiter.
interface interp_ram_arbiter_if #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NUM_CH        = 4
);

  logic [NUM_CH-1:0]               ch_req;
  logic [NUM_CH-1:0]               ch_we;
  logic [NUM_CH-1:0]               ch_lock;
  logic [NUM_CH*ADDRESS_WIDTH-1:0] ch_addr;
  logic [NUM_CH*WORD_SIZE-1:0]     ch_wdata;
  logic [NUM_CH-1:0]               ch_gnt;
  logic [NUM_CH-1:0]               ch_rvalid;
  logic [WORD_SIZE-1:0]            ch_rdata;

  logic                            ram_we;
  logic [ADDRESS_WIDTH-1:0]        ram_addr;
  logic [WORD_SIZE-1:0]            ram_wdata;
  logic [WORD_SIZE-1:0]            ram_rdata;

  // Requesters plus RAM instance.
  modport master (
    output ch_req, ch_we, ch_lock, ch_addr, ch_wdata, ram_rdata,
    input  ch_gnt, ch_rvalid, ch_rdata, ram_we, ram_addr, ram_wdata
  );

  // Arbiter.
  modport slave (
    input  ch_req, ch_we, ch_lock, ch_addr, ch_wdata, ram_rdata,
    output ch_gnt, ch_rvalid, ch_rdata, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/interp_ram_arbiter_picker.sv
// Rotating-priority picker: first requester at or after i_start, wrapping.
module rr_priority_picker
  import interp_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDW    = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDW-1:0]    i_start,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDW-1:0]    o_idx
);

  logic w_found;

  // Two ascending passes: indices at/after the start first, then the wrap-around.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_found && i_req[c] && (c >= 32'(i_start))) begin
        w_found  = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IDW'(c);
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!w_found && i_req[c]) begin
        w_found  = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/interp_ram_arbiter.sv
// N-channel single-port RAM arbiter with read-return tagging and starvation flag.
module interp_ram_arbiter
  import interp_pkg::*;
#(
  parameter  int unsigned WORD_SIZE     = 16,
  parameter  int unsigned ADDRESS_WIDTH = 16,
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned RD_LATENCY    = 1,
  parameter  int unsigned ARB_MODE      = ARB_RR,
  parameter  int unsigned MAX_WAIT      = 64,
  localparam int unsigned IDW           = id_width(NUM_CH),
  localparam int unsigned CW            = clog2(MAX_WAIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  interp_ram_arbiter_if.slave bus,
  output logic                starve_err,
  output logic [IDW-1:0]      starve_ch
);

  logic [IDW-1:0]           r_ptr;
  logic [IDW-1:0]           w_start;
  logic [NUM_CH-1:0]        w_pick;
  logic [NUM_CH-1:0]        w_gnt;
  logic [IDW-1:0]           w_idx;
  logic                     w_any;
  logic                     w_sel_we;
  logic                     w_sel_lock;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [ADDRESS_WIDTH-1:0] r_addr_hold;
  logic [WORD_SIZE-1:0]     w_sel_wdata;
  logic [WORD_SIZE-1:0]     r_wdata_hold;
  rd_tag_t                  r_tag [RD_LATENCY];
  logic [CW-1:0]            r_wait [NUM_CH];
  logic [CW-1:0]            w_wait_nxt [NUM_CH];
  logic                     w_hit;
  logic [IDW-1:0]           w_hit_ch;

  assign w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

  rr_priority_picker #(.NUM_CH(NUM_CH)) u_picker (
    .i_req   (bus.ch_req),
    .i_start (w_start),
    .o_gnt   (w_pick),
    .o_idx   (w_idx)
  );

  // Gating with rst keeps grants and RAM writes quiet while reset is held.
  assign w_gnt = rst ? w_pick : '0;
  assign w_any = |w_gnt;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_lock  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_gnt[c]) begin
        w_sel_we    = bus.ch_we[c];
        w_sel_lock  = bus.ch_lock[c];
        w_sel_addr  = bus.ch_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_wdata = bus.ch_wdata[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign bus.ch_gnt    = w_gnt;
  assign bus.ram_we    = w_any & w_sel_we;
  assign bus.ram_addr  = w_any ? w_sel_addr  : r_addr_hold;
  assign bus.ram_wdata = w_any ? w_sel_wdata : r_wdata_hold;
  assign bus.ch_rdata  = bus.ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else if (w_any) begin
      r_addr_hold  <= w_sel_addr;
      r_wdata_hold <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (ARB_MODE == ARB_FIXED || NUM_CH == 1) begin
      r_ptr <= '0;
    end else if (w_any) begin
      if (w_sel_lock)                      r_ptr <= w_idx;
      else if (w_idx == IDW'(NUM_CH - 1))  r_ptr <= '0;
      else                                 r_ptr <= w_idx + IDW'(1);
    end
  end

  // Read-return tag pipeline; the tail stage lines up with RAM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0].vld <= w_any & ~w_sel_we;
      r_tag[0].id  <= TAG_IDW'(w_idx);
      for (int unsigned i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    bus.ch_rvalid = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.ch_rvalid[c] = r_tag[RD_LATENCY-1].vld &&
                         (r_tag[RD_LATENCY-1].id == TAG_IDW'(c));
    end
  end

  always_comb begin
    w_wait_nxt = '{default: '0};
    w_hit      = 1'b0;
    w_hit_ch   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!bus.ch_req[c] || w_gnt[c])          w_wait_nxt[c] = '0;
      else if (r_wait[c] == CW'(MAX_WAIT))     w_wait_nxt[c] = r_wait[c];
      else                                     w_wait_nxt[c] = r_wait[c] + CW'(1);
      if (!w_hit && (w_wait_nxt[c] == CW'(MAX_WAIT))) begin
        w_hit    = 1'b1;
        w_hit_ch = IDW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait     <= '{default: '0};
      starve_err <= 1'b0;
      starve_ch  <= '0;
    end else begin
      r_wait <= w_wait_nxt;
      if (!starve_err && w_hit) begin
        starve_err <= 1'b1;
        starve_ch  <= w_hit_ch;
      end
    end
  end

endmodule

// File: tb/tb_interp_ram_arbiter.sv
// Directed bench: round-robin arbiter with RAM model, plus a fixed-priority instance.
module tb_interp_ram_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        starve_err_rr, starve_err_fp;
  logic [1:0]  starve_ch_rr, starve_ch_fp;
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [15:0] mem [65536];
  logic [15:0] r_rdata;

  always #5 clk = ~clk;

  interp_ram_arbiter_if #(.WORD_SIZE(16), .ADDRESS_WIDTH(16), .NUM_CH(4)) bus_rr ();
  interp_ram_arbiter_if #(.WORD_SIZE(16), .ADDRESS_WIDTH(16), .NUM_CH(4)) bus_fp ();

  interp_ram_arbiter #(
    .WORD_SIZE(16), .ADDRESS_WIDTH(16), .NUM_CH(4),
    .RD_LATENCY(1), .ARB_MODE(0), .MAX_WAIT(64)
  ) dut_rr (
    .clk(clk), .rst(rst_n), .bus(bus_rr),
    .starve_err(starve_err_rr), .starve_ch(starve_ch_rr)
  );

  interp_ram_arbiter #(
    .WORD_SIZE(16), .ADDRESS_WIDTH(16), .NUM_CH(4),
    .RD_LATENCY(1), .ARB_MODE(1), .MAX_WAIT(8)
  ) dut_fp (
    .clk(clk), .rst(rst_n), .bus(bus_fp),
    .starve_err(starve_err_fp), .starve_ch(starve_ch_fp)
  );

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus_rr.ram_we) mem[bus_rr.ram_addr] <= bus_rr.ram_wdata;
    r_rdata <= mem[bus_rr.ram_addr];
  end
  assign bus_rr.ram_rdata = r_rdata;
  assign bus_fp.ram_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [15:0] preload(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = preload(16'(i));
    bus_rr.ch_req = 4'hF;  bus_rr.ch_we = '0; bus_rr.ch_lock = '0;
    bus_fp.ch_req = 4'h0;  bus_fp.ch_we = '0; bus_fp.ch_lock = '0;
    for (int i = 0; i < 4; i++) begin
      bus_rr.ch_addr[i*16 +: 16]  = 16'h0020 + 16'(i);
      bus_rr.ch_wdata[i*16 +: 16] = '0;
      bus_fp.ch_addr[i*16 +: 16]  = 16'h0040 + 16'(i);
      bus_fp.ch_wdata[i*16 +: 16] = '0;
    end

    // Reset with requests present: nothing may be granted or written.
    sample();
    check("rst_gnt",    32'(bus_rr.ch_gnt),    32'h0);
    check("rst_ramwe",  32'(bus_rr.ram_we),    32'h0);
    check("rst_rvalid", 32'(bus_rr.ch_rvalid), 32'h0);
    check("rst_starve", 32'(starve_err_rr),    32'h0);
    repeat (3) next_cycle();
    bus_rr.ch_req = '0;
    rst_n = 1'b1;
    sample();
    check("idle_gnt",    32'(bus_rr.ch_gnt),    32'h0);
    check("idle_rvalid", 32'(bus_rr.ch_rvalid), 32'h0);
    check("idle_ramwe",  32'(bus_rr.ram_we),    32'h0);

    // Round-robin: all four channels read continuously.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus_rr.ch_req = 4'hF;
      sample();
      check("rr_gnt", 32'(bus_rr.ch_gnt), 32'(1) << (k % 4));
      if (k == 0) begin
        check("rr_rvalid0", 32'(bus_rr.ch_rvalid), 32'h0);
      end else begin
        check("rr_rvalid", 32'(bus_rr.ch_rvalid), 32'(1) << ((k - 1) % 4));
        check("rr_rdata",  32'(bus_rr.ch_rdata),
              32'(preload(16'h0020 + 16'((k - 1) % 4))));
      end
    end
    next_cycle();
    bus_rr.ch_req = '0;
    sample();
    check("rr_tail_rvalid", 32'(bus_rr.ch_rvalid), 32'h8);
    check("rr_tail_rdata",  32'(bus_rr.ch_rdata),  32'(preload(16'h0023)));
    check("rr_tail_gnt",    32'(bus_rr.ch_gnt),    32'h0);

    // Write then read-back on channel 1.
    next_cycle();
    bus_rr.ch_addr[16 +: 16]  = 16'h0010;
    bus_rr.ch_wdata[16 +: 16] = 16'hBEEF;
    bus_rr.ch_we[1]  = 1'b1;
    bus_rr.ch_req[1] = 1'b1;
    sample();
    check("wr_gnt",   32'(bus_rr.ch_gnt),    32'h2);
    check("wr_we",    32'(bus_rr.ram_we),    32'h1);
    check("wr_addr",  32'(bus_rr.ram_addr),  32'h0010);
    check("wr_wdata", 32'(bus_rr.ram_wdata), 32'hBEEF);
    next_cycle();
    bus_rr.ch_we[1] = 1'b0;
    sample();
    check("rd_gnt", 32'(bus_rr.ch_gnt), 32'h2);
    check("rd_we",  32'(bus_rr.ram_we), 32'h0);
    next_cycle();
    bus_rr.ch_req = '0;
    sample();
    check("rd_rvalid",  32'(bus_rr.ch_rvalid), 32'h2);
    check("rd_rdata",   32'(bus_rr.ch_rdata),  32'hBEEF);
    check("hold_addr",  32'(bus_rr.ram_addr),  32'h0010);
    check("hold_we",    32'(bus_rr.ram_we),    32'h0);
    bus_rr.ch_addr[16 +: 16] = 16'h0021;

    // Lock burst on channel 2 (pointer sits at 2 after the channel 1 grants).
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus_rr.ch_req  = 4'b1101;
      bus_rr.ch_lock = 4'b0100;
      sample();
      check("lock_gnt", 32'(bus_rr.ch_gnt), 32'h4);
    end
    next_cycle();
    bus_rr.ch_req  = 4'b1001;
    bus_rr.ch_lock = '0;
    sample();
    check("unlock_gnt", 32'(bus_rr.ch_gnt), 32'h8);
    next_cycle();
    sample();
    check("after_gnt", 32'(bus_rr.ch_gnt), 32'h1);

    // Reset asserted the cycle after a read grant drops the in-flight tag.
    next_cycle();
    bus_rr.ch_req = 4'b0010;
    sample();
    check("mid_gnt", 32'(bus_rr.ch_gnt), 32'h2);
    next_cycle();
    bus_rr.ch_req = '0;
    rst_n = 1'b0;
    sample();
    check("mid_rst_rvalid", 32'(bus_rr.ch_rvalid), 32'h0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    sample();
    check("mid_rel_rvalid", 32'(bus_rr.ch_rvalid), 32'h0);
    next_cycle();
    bus_rr.ch_req = 4'hF;
    sample();
    check("mid_ptr0_gnt",   32'(bus_rr.ch_gnt),    32'h1);
    check("mid_rel2_rvalid", 32'(bus_rr.ch_rvalid), 32'h0);
    next_cycle();
    bus_rr.ch_req = '0;

    // Fixed priority with channel 3 starving behind channel 0.
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      bus_fp.ch_req  = 4'b1001;
      bus_fp.ch_lock = 4'b1000;
      sample();
      check("fp_gnt",    32'(bus_fp.ch_gnt), 32'h1);
      check("fp_starve", 32'(starve_err_fp), (k >= 9) ? 32'h1 : 32'h0);
      check("fp_sch",    32'(starve_ch_fp),  (k >= 9) ? 32'h3 : 32'h0);
    end
    next_cycle();
    bus_fp.ch_req  = '0;
    bus_fp.ch_lock = '0;
    repeat (2) next_cycle();
    sample();
    check("fp_sticky",     32'(starve_err_fp), 32'h1);
    check("fp_sticky_ch",  32'(starve_ch_fp),  32'h3);
    check("fp_idle_gnt",   32'(bus_fp.ch_gnt), 32'h0);
    check("rr_no_starve",  32'(starve_err_rr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
